// File: rtl/debounce_channel.sv
// Single-channel switch debouncer with event pulses.
//
// Raw input is passed through a SYNC_STAGES-flop synchroniser, then accepted
// as the new stable level only after it has disagreed with the current stable
// level for DEBOUNCE_CYCLES consecutive cycles. Press/release pulses coincide
// with the debounced edge; a long-press pulse fires once after the level has
// been held high for LONG_PRESS_CYCLES; the toggle flips on each short-press
// release.
//
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset, clears every flop
//   i_sw       raw switch input (asynchronous, 1 = pressed)
//   o_sw       debounced level
//   o_press    1-cycle pulse on debounced rising edge
//   o_release  1-cycle pulse on debounced falling edge
//   o_long     1-cycle pulse once the press has lasted LONG_PRESS_CYCLES
//   o_toggle   level that flips on release of a short press
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int SYNC_STAGES       = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_sw,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_toggle
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  logic              stable_q,     stable_d;
  logic [DB_W-1:0]   db_cnt_q,     db_cnt_d;
  logic [HOLD_W-1:0] hold_q,       hold_d;
  logic              long_fired_q, long_fired_d;
  logic              press_q,      press_d;
  logic              release_q,    release_d;
  logic              long_q,       long_d;
  logic              toggle_q,     toggle_d;

  logic accept;
  logic fall;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    // The synchronised level has disagreed for DEBOUNCE_CYCLES edges in a row.
    accept   = (sync != stable_q) && (db_cnt_q == DB_LAST);
    fall     = accept && !sync;
    stable_d = accept ? sync : stable_q;

    // Any agreement, even for one cycle, restarts the qualification window.
    if ((sync == stable_q) || accept) begin
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    press_d   = accept && sync;
    release_d = fall;

    // Hold counter starts from zero in the press cycle and saturates so the
    // long event cannot repeat within one press.
    if (!stable_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_W'(1);
    end else begin
      hold_d = hold_q;
    end

    // A release landing on the terminal cycle suppresses the long event.
    long_d = stable_q && !fall && (hold_q == HOLD_LAST) && !long_fired_q;

    if (fall) begin
      long_fired_d = 1'b0;
    end else if (long_d) begin
      long_fired_d = 1'b1;
    end else begin
      long_fired_d = long_fired_q;
    end

    toggle_d = (fall && !long_fired_q) ? !toggle_q : toggle_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q       <= '0;
      stable_q     <= 1'b0;
      db_cnt_q     <= '0;
      hold_q       <= '0;
      long_fired_q <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
      toggle_q     <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], i_sw};
      stable_q     <= stable_d;
      db_cnt_q     <= db_cnt_d;
      hold_q       <= hold_d;
      long_fired_q <= long_fired_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
      toggle_q     <= toggle_d;
    end
  end

  assign o_sw      = stable_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_toggle  = toggle_q;

endmodule

// File: rtl/debounce_multi_edge.sv
// Multi-channel switch debouncer: NUM_CH independent debounce_channel
// instances, outputs gathered into per-function buses (bit n = channel n).
//
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_sw       raw switch inputs, 1 = pressed
//   o_sw       debounced levels
//   o_press    1-cycle pulses on debounced rising edges
//   o_release  1-cycle pulses on debounced falling edges
//   o_long     1-cycle pulses when a press has lasted LONG_PRESS_CYCLES
//   o_toggle   per-channel levels flipping on short-press release
module debounce_multi_edge #(
  parameter int NUM_CH            = 4,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int SYNC_STAGES       = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_sw,
  output logic [NUM_CH-1:0] o_sw,
  output logic [NUM_CH-1:0] o_press,
  output logic [NUM_CH-1:0] o_release,
  output logic [NUM_CH-1:0] o_long,
  output logic [NUM_CH-1:0] o_toggle
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .SYNC_STAGES      (SYNC_STAGES)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_sw     (i_sw[g]),
      .o_sw     (o_sw[g]),
      .o_press  (o_press[g]),
      .o_release(o_release[g]),
      .o_long   (o_long[g]),
      .o_toggle (o_toggle[g])
    );
  end

endmodule

// File: tb/tb_debounce_multi_edge.sv
// Bench for debounce_multi_edge with NUM_CH=4, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=10, SYNC_STAGES=2. Expected pulse events are queued with
// the clock edge they must appear on; levels are compared directly.
module tb_debounce_multi_edge;

  localparam int NCH = 4;
  localparam int LAT = 6;   // SYNC_STAGES + DEBOUNCE_CYCLES
  localparam int LP  = 10;  // LONG_PRESS_CYCLES

  logic           clk;
  logic           i_rst;
  logic [NCH-1:0] i_sw;
  logic [NCH-1:0] o_sw, o_press, o_release, o_long, o_toggle;

  debounce_multi_edge #(
    .NUM_CH(NCH), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(LP), .SYNC_STAGES(2)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_sw(i_sw),
    .o_sw(o_sw), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_toggle(o_toggle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int cyc;
    int ch;
    int kind;   // 0 press, 1 release, 2 long
  } ev_t;

  typedef struct {
    logic [NCH-1:0] sw;
    int             n;
    logic [NCH-1:0] pm;  int poff;
    logic [NCH-1:0] rm;  int roff;
    logic [NCH-1:0] lm;  int loff;
    logic [NCH-1:0] exp_sw;
    logic [NCH-1:0] exp_tog;
  } vec_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   now    = 0;
  vec_t tbl[10];

  function automatic string kname(input int k);
    case (k)
      0:       return "press";
      1:       return "release";
      default: return "long";
    endcase
  endfunction

  task automatic push(input logic [NCH-1:0] mask, input int kind, input int cyc);
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) exp_q.push_back('{cyc: cyc, ch: c, kind: kind});
    end
  endtask

  task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, now, act, exp);
    end
  endtask

  // Every observed pulse must match a queued event for this edge; any queued
  // event whose edge has passed without being seen is a miss.
  task automatic monitor();
    logic [NCH-1:0] pv[3];
    bit found;
    pv[0] = o_press;
    pv[1] = o_release;
    pv[2] = o_long;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (pv[k][c]) begin
          checks++;
          found = 1'b0;
          for (int i = 0; i < exp_q.size() && !found; i++) begin
            if (exp_q[i].cyc == now && exp_q[i].ch == c && exp_q[i].kind == k) begin
              exp_q.delete(i);
              found = 1'b1;
            end
          end
          if (!found) begin
            errors++;
            $display("FAIL unexpected %s ch%0d at cycle %0d: got 1, expected 0", kname(k), c, now);
          end
        end
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= now) begin
        checks++;
        errors++;
        $display("FAIL missing %s ch%0d due cycle %0d (now %0d): got 0, expected 1",
                 kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].cyc, now);
        exp_q.delete(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    now++;
    #1;
    monitor();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_sw"},      o_sw,      '0);
    chk({name, "_press"},   o_press,   '0);
    chk({name, "_release"}, o_release, '0);
    chk({name, "_long"},    o_long,    '0);
    chk({name, "_toggle"},  o_toggle,  '0);
  endtask

  task automatic do_reset();
    i_sw  = '0;
    i_rst = 1'b1;
    #1;
    chk_all_zero("rst_async");
    ticks(2);
    i_rst = 1'b0;
    ticks(1);
  endtask

  initial begin
    // Short and long presses, plus both sides of the release-vs-long boundary.
    tbl[0] = '{4'b0010,  8, 4'b0010, 6, 4'b0000, 0, 4'b0000,  0, 4'b0010, 4'b0000};
    tbl[1] = '{4'b0000,  8, 4'b0000, 0, 4'b0010, 6, 4'b0000,  0, 4'b0000, 4'b0010};
    tbl[2] = '{4'b0100, 20, 4'b0100, 6, 4'b0000, 0, 4'b0100, 16, 4'b0100, 4'b0010};
    tbl[3] = '{4'b0000,  8, 4'b0000, 0, 4'b0100, 6, 4'b0000,  0, 4'b0000, 4'b0010};
    tbl[4] = '{4'b0100,  8, 4'b0100, 6, 4'b0000, 0, 4'b0000,  0, 4'b0100, 4'b0010};
    tbl[5] = '{4'b0000,  8, 4'b0000, 0, 4'b0100, 6, 4'b0000,  0, 4'b0000, 4'b0110};
    tbl[6] = '{4'b1000, 10, 4'b1000, 6, 4'b0000, 0, 4'b0000,  0, 4'b1000, 4'b0110};
    tbl[7] = '{4'b0000,  8, 4'b0000, 0, 4'b1000, 6, 4'b0000,  0, 4'b0000, 4'b1110};
    tbl[8] = '{4'b1000, 11, 4'b1000, 6, 4'b0000, 0, 4'b0000,  0, 4'b1000, 4'b1110};
    tbl[9] = '{4'b0000,  8, 4'b0000, 0, 4'b1000, 6, 4'b1000,  5, 4'b0000, 4'b1110};

    i_rst = 1'b0;
    i_sw  = '0;
    #2;

    // Switches held through reset: nothing until LAT edges after deassert.
    i_rst = 1'b1;
    i_sw  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all_zero("in_reset");
    end
    i_rst = 1'b0;
    push(4'hF, 0, now + LAT);
    ticks(LAT - 1);
    chk("pre_press_sw", o_sw, 4'h0);
    ticks(3);
    chk("held_sw", o_sw, 4'hF);
    do_reset();

    // Bounce on ch0: 3-cycle runs never qualify, then a clean rise.
    for (int s = 0; s < 10; s++) begin
      i_sw[0] = (s % 2 == 0);
      ticks(3);
    end
    chk("bounce_sw", o_sw, 4'h0);
    i_sw = 4'b0001;
    push(4'b0001, 0, now + LAT);
    push(4'b0001, 2, now + LAT + LP);
    ticks(8);
    chk("bounce_final_sw", o_sw, 4'b0001);
    ticks(12);
    do_reset();

    for (int v = 0; v < 10; v++) begin
      i_sw = tbl[v].sw;
      if (tbl[v].pm != 0) push(tbl[v].pm, 0, now + tbl[v].poff);
      if (tbl[v].rm != 0) push(tbl[v].rm, 1, now + tbl[v].roff);
      if (tbl[v].lm != 0) push(tbl[v].lm, 2, now + tbl[v].loff);
      ticks(tbl[v].n);
      chk($sformatf("vec%0d_sw", v),     o_sw,     tbl[v].exp_sw);
      chk($sformatf("vec%0d_toggle", v), o_toggle, tbl[v].exp_tog);
    end
    do_reset();

    // All channels together, then ch3 bounces while the others hold.
    i_sw = 4'hF;
    push(4'hF, 0, now + LAT);
    push(4'hF, 2, now + LAT + LP);
    ticks(8);
    for (int s = 0; s < 4; s++) begin
      i_sw[3] = (s % 2 == 1);
      ticks(3);
      chk($sformatf("iso_sw_%0d", s), o_sw, 4'hF);
    end
    i_sw = 4'h0;
    push(4'hF, 1, now + LAT);
    ticks(8);
    chk("iso_rel_sw", o_sw, 4'h0);
    chk("iso_rel_toggle", o_toggle, 4'h0);
    do_reset();

    // Reset with ch1 one cycle short of long and ch0 one edge short of accept.
    i_sw = 4'b0010;
    push(4'b0010, 0, now + LAT);
    ticks(10);
    i_sw = 4'b0011;
    ticks(5);
    i_rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    i_sw = 4'h0;
    ticks(2);
    i_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_all_zero("post_midrst");
    end

    ticks(4);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      errors++;
      $display("FAIL leftover %s ch%0d due cycle %0d: got 0, expected 1",
               kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
